clk_rst_gen: RTL and testbench

Stage directly downstream of the system PLL (64 MHz from a 40 MHz board oscillator). Consumes the PLL output clock and lock flag. Produces the synchronous system reset, the CPU clock-enable strobe (normal/turbo rate) and the video pixel clock-enable strobe. The whole Micro80 core runs on clk and is gated by these enables.

---
 rtl/clk_rst_pkg.sv | 21 ++
 rtl/clk_en_div.sv | 33 +++
 rtl/clk_rst_gen.sv | 154 +++++++++++++++
 tb/tb_clk_rst_gen.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/clk_rst_pkg.sv
// rtl/clk_rst_pkg.sv - shared types, default dividers and width helper for clk_rst_gen
package clk_rst_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STRETCH   = 2'd1,
        RUN       = 2'd2
    } rst_state_t;

    localparam int DEF_RST_CYCLES   = 65536;
    localparam int DEF_DEB_CYCLES   = 640000;
    localparam int DEF_CPU_DIV      = 32;
    localparam int DEF_CPU_DIV_FAST = 16;
    localparam int DEF_PIX_DIV      = 8;

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clk_en_div.sv
// rtl/clk_en_div.sv - wrapping counter producing a one-cycle enable strobe every (last+1) cycles
module clk_en_div
    import clk_rst_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [W-1:0] last,
    output logic         ce
);

    logic [W-1:0] cnt;
    logic [W-1:0] last_q;

    // The terminal count is captured only on clear or wrap so a period is never cut short.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt    <= '0;
            last_q <= last;
            ce     <= 1'b0;
        end else if (cnt == last_q) begin
            cnt    <= '0;
            last_q <= last;
            ce     <= 1'b1;
        end else begin
            cnt    <= cnt + W'(1);
            ce     <= 1'b0;
        end
    end

endmodule

// File: rtl/clk_rst_gen.sv
// rtl/clk_rst_gen.sv - system reset sequencer, lock/button conditioning and clock-enable strobes
module clk_rst_gen
    import clk_rst_pkg::*;
#(
    parameter int RST_CYCLES   = DEF_RST_CYCLES,
    parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
    parameter int CPU_DIV      = DEF_CPU_DIV,
    parameter int CPU_DIV_FAST = DEF_CPU_DIV_FAST,
    parameter int PIX_DIV      = DEF_PIX_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_lock,
    input  logic btn_rst_n,
    input  logic turbo,
    output logic sys_rst,
    output logic cpu_ce,
    output logic pix_ce,
    output logic pll_ok
);

    localparam int RST_W   = cnt_width(RST_CYCLES);
    localparam int DEB_W   = cnt_width(DEB_CYCLES);
    localparam int CPU_MAX = (CPU_DIV > CPU_DIV_FAST) ? CPU_DIV : CPU_DIV_FAST;
    localparam int CPU_W   = cnt_width(CPU_MAX);
    localparam int PIX_W   = cnt_width(PIX_DIV);

    localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [CPU_W-1:0] CPU_LAST  = CPU_W'(CPU_DIV - 1);
    localparam logic [CPU_W-1:0] FAST_LAST = CPU_W'(CPU_DIV_FAST - 1);
    localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(PIX_DIV - 1);

    if (CPU_DIV < 2 || CPU_DIV_FAST < 2 || PIX_DIV < 2) begin : g_bad_div
        $error("clk_rst_gen: all divide values must be at least 2");
    end

    logic             lock_s1;
    logic             btn_s1;
    logic             btn_s2;
    logic             btn_db;
    logic [DEB_W-1:0] deb_cnt;
    logic             pressed;

    rst_state_t       state;
    rst_state_t       state_nxt;
    logic [RST_W-1:0] st_cnt;
    logic [RST_W-1:0] st_cnt_nxt;
    logic             sys_rst_nxt;

    logic [CPU_W-1:0] cpu_last;
    logic             cpu_clr;

    // Synchronisers idle at "no lock" and "button released".
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_s1 <= 1'b0;
            pll_ok  <= 1'b0;
            btn_s1  <= 1'b1;
            btn_s2  <= 1'b1;
        end else begin
            lock_s1 <= pll_lock;
            pll_ok  <= lock_s1;
            btn_s1  <= btn_rst_n;
            btn_s2  <= btn_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_db  <= 1'b1;
            deb_cnt <= '0;
        end else if (btn_s2 == btn_db) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            btn_db  <= btn_s2;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
        end
    end

    assign pressed = ~btn_db;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= WAIT_LOCK;
            st_cnt  <= '0;
            sys_rst <= 1'b1;
        end else begin
            state   <= state_nxt;
            st_cnt  <= st_cnt_nxt;
            sys_rst <= sys_rst_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        st_cnt_nxt = st_cnt;
        case (state)
            WAIT_LOCK: begin
                if (pll_ok && !pressed) begin
                    state_nxt  = STRETCH;
                    st_cnt_nxt = '0;
                end
            end
            STRETCH: begin
                if (!pll_ok) begin
                    state_nxt = WAIT_LOCK;
                end else if (pressed) begin
                    st_cnt_nxt = '0;
                end else if (st_cnt == RST_LAST) begin
                    state_nxt = RUN;
                end else begin
                    st_cnt_nxt = st_cnt + RST_W'(1);
                end
            end
            RUN: begin
                if (!pll_ok) begin
                    state_nxt = WAIT_LOCK;
                end else if (pressed) begin
                    state_nxt  = STRETCH;
                    st_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt  = WAIT_LOCK;
                st_cnt_nxt = '0;
            end
        endcase
        sys_rst_nxt = (state_nxt != RUN);
    end

    // Clearing on the upcoming value as well keeps cpu_ce low on every cycle sys_rst is high.
    assign cpu_clr  = sys_rst | sys_rst_nxt;
    assign cpu_last = turbo ? FAST_LAST : CPU_LAST;

    clk_en_div #(.W(CPU_W)) u_cpu_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (cpu_clr),
        .last (cpu_last),
        .ce   (cpu_ce)
    );

    clk_en_div #(.W(PIX_W)) u_pix_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (1'b0),
        .last (PIX_LAST),
        .ce   (pix_ce)
    );

endmodule

// File: tb/tb_clk_rst_gen.sv
// tb/tb_clk_rst_gen.sv - randomized self-checking bench for clk_rst_gen against a timestamp model
module tb_clk_rst_gen;

    localparam int RST  = 16;
    localparam int DEB  = 4;
    localparam int DIV  = 8;
    localparam int FAST = 4;
    localparam int PIX  = 2;

    localparam int M_WAIT    = 0;
    localparam int M_STRETCH = 1;
    localparam int M_RUN     = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pll_lock = 1'b0;
    logic btn_rst_n = 1'b1;
    logic turbo = 1'b0;
    logic sys_rst, cpu_ce, pix_ce, pll_ok;

    int n_checks = 0;
    int n_fail = 0;

    clk_rst_gen #(
        .RST_CYCLES   (RST),
        .DEB_CYCLES   (DEB),
        .CPU_DIV      (DIV),
        .CPU_DIV_FAST (FAST),
        .PIX_DIV      (PIX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pll_lock  (pll_lock),
        .btn_rst_n (btn_rst_n),
        .turbo     (turbo),
        .sys_rst   (sys_rst),
        .cpu_ce    (cpu_ce),
        .pix_ce    (pix_ce),
        .pll_ok    (pll_ok)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Reference model: edge-numbered events and timestamps derived from the behavioural rules.
    int m_n = 0;
    bit started = 0;
    bit m_ok, m_lk1, m_bs1, m_bs2, m_db, m_sys, m_cpu, m_pix;
    int m_mode, m_sstart, m_next_cpu, m_pix_base;
    bit dq[$];

    always @(posedge clk) begin
        bit old_ok, old_db, old_bs2, old_sys, all_diff;
        m_n++;
        if (rst) begin
            started = 1;
            m_ok = 0; m_lk1 = 0; m_bs1 = 1; m_bs2 = 1; m_db = 1;
            dq.delete();
            m_mode = M_WAIT; m_sys = 1; m_cpu = 0; m_pix = 0;
            m_pix_base = m_n; m_next_cpu = -1;
        end else begin
            old_ok = m_ok; old_db = m_db; old_bs2 = m_bs2; old_sys = m_sys;
            dq.push_back(old_bs2);
            if (dq.size() > DEB) void'(dq.pop_front());
            all_diff = (dq.size() == DEB);
            foreach (dq[i]) if (dq[i] == old_db) all_diff = 0;
            if (all_diff) m_db = !old_db;
            case (m_mode)
                M_WAIT: if (old_ok && old_db) begin m_mode = M_STRETCH; m_sstart = m_n; end
                M_STRETCH: begin
                    if (!old_ok) m_mode = M_WAIT;
                    else if (!old_db) m_sstart = m_n;
                    else if (m_n - m_sstart == RST) m_mode = M_RUN;
                end
                default: begin
                    if (!old_ok) m_mode = M_WAIT;
                    else if (!old_db) begin m_mode = M_STRETCH; m_sstart = m_n; end
                end
            endcase
            m_sys = (m_mode != M_RUN);
            if (old_sys || m_sys) begin
                m_cpu = 0;
                m_next_cpu = m_n + (turbo ? FAST : DIV);
            end else if (m_n == m_next_cpu) begin
                m_cpu = 1;
                m_next_cpu = m_n + (turbo ? FAST : DIV);
            end else begin
                m_cpu = 0;
            end
            m_pix = (m_n != m_pix_base) && ((m_n - m_pix_base) % PIX == 0);
            m_ok = m_lk1; m_lk1 = pll_lock;
            m_bs2 = m_bs1; m_bs1 = btn_rst_n;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("sys_rst", sys_rst, m_sys);
            check("cpu_ce", cpu_ce, m_cpu);
            check("pix_ce", pix_ce, m_pix);
            check("pll_ok", pll_ok, m_ok);
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic run(input int k, input int p_turbo);
        repeat (k) begin
            @(negedge clk);
            if (p_turbo > 0 && $urandom_range(p_turbo - 1) == 0) turbo = ~turbo;
        end
    endtask

    initial begin
        // power-up
        cyc(3);
        rst = 0;
        cyc(7);
        pll_lock = 1;
        run(50, 0);
        // turbo changes while running
        run(120, 6);
        turbo = 0;
        run(20, 0);
        // lock loss and relock
        pll_lock = 0;
        cyc(5);
        pll_lock = 1;
        run(45, 0);
        // bouncy button, then a real press and release
        repeat (10) begin
            btn_rst_n = ~btn_rst_n;
            cyc(2);
        end
        btn_rst_n = 1;
        run(20, 0);
        btn_rst_n = 0;
        cyc(8);
        btn_rst_n = 1;
        run(40, 0);
        // press during the stretch interval
        pll_lock = 0;
        cyc(5);
        pll_lock = 1;
        cyc(14);
        btn_rst_n = 0;
        cyc(6);
        btn_rst_n = 1;
        run(40, 0);
        // block reset landing just before a cpu_ce
        for (int i = 0; i < 40; i++) begin
            if (m_next_cpu == m_n + 1 && !m_sys) break;
            @(negedge clk);
        end
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("rst_cpu_ce", cpu_ce, 0);
        check("rst_sys_rst", sys_rst, 1);
        check("rst_pll_ok", pll_ok, 0);
        run(40, 0);
        // random soak
        repeat (2500) begin
            @(negedge clk);
            if ($urandom_range(pll_lock ? 199 : 9) == 0) pll_lock = ~pll_lock;
            if ($urandom_range(btn_rst_n ? 59 : 4) == 0) btn_rst_n = ~btn_rst_n;
            if ($urandom_range(24) == 0) turbo = ~turbo;
            rst = ($urandom_range(599) == 0);
        end
        rst = 0;
        cyc(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
